// File: rtl/autosa_csb_pkg.sv
// Shared types and helpers for the multi-channel APB-to-CSB bridge.
package autosa_csb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } csb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'h0;

    // A single-channel build still needs a 1-bit select field.
    function automatic int ch_width(input int nch);
        if (nch <= 1) begin
            return 1;
        end
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/autosa_csb_timeout.sv
// Per-access timeout counter: saturates at TIMEOUT and flags expiry; never expires when TIMEOUT=0.
module autosa_csb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/autosa_apb2csb_mc.sv
// APB3 slave that forwards each access to one of NCH CSB targets and returns
// the read data / write completion, with a per-access timeout reported as PSLVERR.
module autosa_apb2csb_mc
    import autosa_csb_pkg::*;
#(
    parameter int APB_AW     = 32,
    parameter int DW         = 32,
    parameter int CSB_AW     = 16,
    parameter int NCH        = 2,
    parameter int CH_SEL_LSB = 18,
    parameter int WR_NPOSTED = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              core_clk,
    input  logic              rstn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [DW-1:0]     pwdata,
    output logic [DW-1:0]     prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NCH-1:0]    csb2autosa_valid,
    input  logic [NCH-1:0]    csb2autosa_ready,
    output logic [CSB_AW-1:0] csb2autosa_addr,
    output logic [DW-1:0]     csb2autosa_wdat,
    output logic              csb2autosa_write,
    output logic              csb2autosa_nposted,
    input  logic [NCH-1:0]    autosa2csb_valid,
    input  logic [NCH*DW-1:0] autosa2csb_data,
    input  logic [NCH-1:0]    autosa2csb_wr_complete
);

    localparam int CHW     = ch_width(NCH);
    localparam bit NPOSTED = (WR_NPOSTED != 0);

    csb_state_e        state_q, state_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [CSB_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic              write_q, write_d;
    logic              nposted_q, nposted_d;
    logic [NCH-1:0]    valid_q, valid_d;
    logic [DW-1:0]     prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;

    logic              tmo_clr, tmo_en, tmo_expired;
    logic [CHW-1:0]    sel_ch;
    logic              sel_bad;
    logic              ch_ready, rsp_valid, rsp_wr_done;
    logic [DW-1:0]     rsp_data;
    logic              unused_paddr;

    assign sel_ch       = paddr[CH_SEL_LSB +: CHW];
    assign sel_bad      = (int'(sel_ch) >= NCH);
    assign unused_paddr = ^paddr;

    // Only the latched channel's handshake and response lines are looked at.
    always_comb begin
        ch_ready    = 1'b0;
        rsp_valid   = 1'b0;
        rsp_wr_done = 1'b0;
        rsp_data    = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == CHW'(c)) begin
                ch_ready    = csb2autosa_ready[c];
                rsp_valid   = autosa2csb_valid[c];
                rsp_wr_done = autosa2csb_wr_complete[c];
                rsp_data    = autosa2csb_data[c*DW +: DW];
            end
        end
    end

    autosa_csb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (core_clk),
        .rst_n   (rstn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Handshakes and responses are tested before expiry so a same-cycle response wins.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        write_d   = write_q;
        prdata_d  = prdata_q;
        pslverr_d = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && penable && !pready_q) begin
                    ch_d    = sel_ch;
                    addr_d  = paddr[CSB_AW+1:2];
                    wdat_d  = pwdata;
                    write_d = pwrite;
                    if (sel_bad) begin
                        state_d   = DONE;
                        pslverr_d = 1'b1;
                        prdata_d  = DW'(ERR_RDATA);
                    end else begin
                        state_d = REQ;
                        tmo_clr = 1'b1;
                    end
                end
            end
            REQ: begin
                tmo_en = 1'b1;
                if (ch_ready) begin
                    state_d = (write_q && !NPOSTED) ? DONE : WAIT;
                end else if (tmo_expired) begin
                    state_d   = DONE;
                    pslverr_d = 1'b1;
                    prdata_d  = DW'(ERR_RDATA);
                end
            end
            WAIT: begin
                tmo_en = 1'b1;
                if (write_q ? rsp_wr_done : rsp_valid) begin
                    state_d = DONE;
                    if (!write_q) begin
                        prdata_d = rsp_data;
                    end
                end else if (tmo_expired) begin
                    state_d   = DONE;
                    pslverr_d = 1'b1;
                    prdata_d  = DW'(ERR_RDATA);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pready_d  = (state_d == DONE);
        nposted_d = write_d & NPOSTED;
        valid_d   = '0;
        if (state_d == REQ) begin
            for (int c = 0; c < NCH; c++) begin
                valid_d[c] = (ch_d == CHW'(c));
            end
        end
    end

    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            addr_q    <= '0;
            wdat_q    <= '0;
            write_q   <= 1'b0;
            nposted_q <= 1'b0;
            valid_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            write_q   <= write_d;
            nposted_q <= nposted_d;
            valid_q   <= valid_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata             = prdata_q;
    assign pready             = pready_q;
    assign pslverr            = pslverr_q;
    assign csb2autosa_valid   = valid_q;
    assign csb2autosa_addr    = addr_q;
    assign csb2autosa_wdat    = wdat_q;
    assign csb2autosa_write   = write_q;
    assign csb2autosa_nposted = nposted_q;

endmodule

// File: tb/tb_autosa_apb2csb_mc.sv
// Bench for autosa_apb2csb_mc: directed APB accesses against two bridge builds
// (3 channels non-posted with timeout 8; 2 channels posted without timeout).
module tb_autosa_apb2csb_mc;

    localparam int EW = 50;  // {chk_data, cycle[15:0], pslverr, prdata[31:0]}

    logic        core_clk = 1'b0;
    logic        rstn;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [2:0]  ready, rvalid, wrc;
    logic [95:0] rdata;

    logic [31:0] prdata_a, wdat_a, prdata_b, wdat_b;
    logic        pready_a, pslverr_a, write_a, nposted_a;
    logic        pready_b, pslverr_b, write_b, nposted_b;
    logic [2:0]  valid_a;
    logic [1:0]  valid_b;
    logic [15:0] addr_a, addr_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    autosa_apb2csb_mc #(.NCH(3), .TIMEOUT(8), .WR_NPOSTED(1)) u_dut_a (
        .core_clk               (core_clk),
        .rstn                   (rstn),
        .psel                   (psel_a),
        .penable                (penable),
        .pwrite                 (pwrite),
        .paddr                  (paddr),
        .pwdata                 (pwdata),
        .prdata                 (prdata_a),
        .pready                 (pready_a),
        .pslverr                (pslverr_a),
        .csb2autosa_valid       (valid_a),
        .csb2autosa_ready       (ready),
        .csb2autosa_addr        (addr_a),
        .csb2autosa_wdat        (wdat_a),
        .csb2autosa_write       (write_a),
        .csb2autosa_nposted     (nposted_a),
        .autosa2csb_valid       (rvalid),
        .autosa2csb_data        (rdata),
        .autosa2csb_wr_complete (wrc)
    );

    autosa_apb2csb_mc #(.NCH(2), .TIMEOUT(0), .WR_NPOSTED(0)) u_dut_b (
        .core_clk               (core_clk),
        .rstn                   (rstn),
        .psel                   (psel_b),
        .penable                (penable),
        .pwrite                 (pwrite),
        .paddr                  (paddr),
        .pwdata                 (pwdata),
        .prdata                 (prdata_b),
        .pready                 (pready_b),
        .pslverr                (pslverr_b),
        .csb2autosa_valid       (valid_b),
        .csb2autosa_ready       (ready[1:0]),
        .csb2autosa_addr        (addr_b),
        .csb2autosa_wdat        (wdat_b),
        .csb2autosa_write       (write_b),
        .csb2autosa_nposted     (nposted_b),
        .autosa2csb_valid       (rvalid[1:0]),
        .autosa2csb_data        (rdata[63:0]),
        .autosa2csb_wr_complete (wrc[1:0])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    // One APB access; the expected completion (cycle, pslverr, prdata) is queued for the monitor.
    task automatic apb_xfer(input bit to_b, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int lat, input bit exp_err,
                            input bit chk_data, input logic [31:0] exp_data);
        int t;
        bit got;
        logic [EW-1:0] e;
        if (to_b) psel_b = 1'b1;
        else      psel_a = 1'b1;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        penable = 1'b0;
        wait_cyc(1);
        penable = 1'b1;
        t = cyc;
        e = {chk_data, 16'(t + lat), exp_err, exp_data};
        if (to_b) exp_b_q.push_back(e);
        else      exp_a_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge core_clk);
            if (to_b ? pready_b : pready_a) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL apb_pready_timeout: got no pready expected one at cycle %0d", t + lat);
        end
        wait_cyc(1);
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    always @(negedge core_clk) begin : mon_a
        logic [EW-1:0] e;
        if (rstn && pready_a) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_pready: got pready at cycle %0d expected none", cyc);
            end else begin
                e = exp_a_q.pop_front();
                check("a_pready_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
                check("a_pslverr", 64'(pslverr_a), 64'(e[32]));
                if (e[49]) check("a_prdata", 64'(prdata_a), 64'(e[31:0]));
            end
        end
    end

    always @(negedge core_clk) begin : mon_b
        logic [EW-1:0] e;
        if (rstn && pready_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_pready: got pready at cycle %0d expected none", cyc);
            end else begin
                e = exp_b_q.pop_front();
                check("b_pready_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
                check("b_pslverr", 64'(pslverr_b), 64'(e[32]));
                if (e[49]) check("b_prdata", 64'(prdata_b), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ready = '0; rvalid = '0; wrc = '0; rdata = '0;
        wait_cyc(2);
        check("rst_pready", 64'(pready_a), 64'h0);
        check("rst_valid", 64'(valid_a), 64'h0);
        rstn = 1'b1;
        wait_cyc(1);
        check("rst_prdata", 64'(prdata_a), 64'h0);
        check("rst_pslverr", 64'(pslverr_a), 64'h0);
        check("rst_addr", 64'(addr_a), 64'h0);
        check("rst_b_valid", 64'(valid_b), 64'h0);

        // Read ch1, ready at once, data one cycle later
        ready = 3'b010;
        fork
            apb_xfer(1'b0, 1'b0, 32'h0004_0010, 32'h0, 3, 1'b0, 1'b1, 32'hCAFE_0001);
            begin
                wait_cyc(2);
                check("t1_valid", 64'(valid_a), 64'h2);
                check("t1_addr", 64'(addr_a), 64'h4);
                check("t1_write", 64'(write_a), 64'h0);
                check("t1_nposted", 64'(nposted_a), 64'h0);
                wait_cyc(1);
                rvalid = 3'b010;
                rdata[63:32] = 32'hCAFE_0001;
                wait_cyc(1);
                rvalid = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(1);

        // Non-posted write ch0, completion 5 cycles after the request
        ready = 3'b001;
        fork
            apb_xfer(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 7, 1'b0, 1'b0, 32'h0);
            begin
                wait_cyc(2);
                check("t2_valid", 64'(valid_a), 64'h1);
                check("t2_addr", 64'(addr_a), 64'h8);
                check("t2_wdat", 64'(wdat_a), 64'h1234_5678);
                check("t2_write", 64'(write_a), 64'h1);
                check("t2_nposted", 64'(nposted_a), 64'h1);
                wait_cyc(1);
                check("t2_valid_wait", 64'(valid_a), 64'h0);
                wait_cyc(4);
                wrc = 3'b001;
                wait_cyc(1);
                wrc = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(1);

        // Posted write on the second build: done right after handshake, completion ignored
        ready = 3'b010;
        fork
            apb_xfer(1'b1, 1'b1, 32'h0004_0000, 32'hA5A5_0F0F, 2, 1'b0, 1'b0, 32'h0);
            begin
                wait_cyc(2);
                check("t2p_valid", 64'(valid_b), 64'h2);
                check("t2p_wdat", 64'(wdat_b), 64'hA5A5_0F0F);
                check("t2p_nposted", 64'(nposted_b), 64'h0);
                wait_cyc(1);
                wrc = 3'b010;
                wait_cyc(2);
                wrc = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(1);

        // Channel 3 does not exist in the 3-channel build
        ready = 3'b111;
        fork
            apb_xfer(1'b0, 1'b0, 32'h000C_0000, 32'h0, 1, 1'b1, 1'b0, 32'h0);
            begin
                wait_cyc(2);
                check("t3_no_valid", 64'(valid_a), 64'h0);
            end
        join
        ready = '0;
        wait_cyc(1);

        // Read ch2 never accepted: timeout, then late data, then a good read
        fork
            apb_xfer(1'b0, 1'b0, 32'h0008_0004, 32'h0, 10, 1'b1, 1'b1, 32'h0);
            begin
                wait_cyc(10);
                check("t4_valid_held", 64'(valid_a), 64'h4);
                check("t4_addr", 64'(addr_a), 64'h1);
                wait_cyc(1);
                check("t4_valid_dropped", 64'(valid_a), 64'h0);
                wait_cyc(1);
                rvalid = 3'b100;
                rdata[95:64] = 32'hDEAD_BEEF;
                wait_cyc(1);
                rvalid = 3'b000;
            end
        join
        ready = 3'b100;
        fork
            apb_xfer(1'b0, 1'b0, 32'h0008_0008, 32'h0, 3, 1'b0, 1'b1, 32'h0BAD_F00D);
            begin
                wait_cyc(3);
                rvalid = 3'b100;
                rdata[95:64] = 32'h0BAD_F00D;
                wait_cyc(1);
                rvalid = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(1);

        // Wrong-channel data and a stray completion are ignored; data on the expiry cycle wins
        ready = 3'b001;
        fork
            apb_xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 10, 1'b0, 1'b1, 32'h5A5A_0005);
            begin
                wait_cyc(5);
                rvalid = 3'b010;
                rdata[63:32] = 32'h1111_1111;
                wrc = 3'b001;
                wait_cyc(1);
                rvalid = 3'b000;
                wrc = 3'b000;
                wait_cyc(4);
                rvalid = 3'b001;
                rdata[31:0] = 32'h5A5A_0005;
                wait_cyc(1);
                rvalid = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(1);

        // Reset while waiting for read data
        ready = 3'b010;
        pwrite = 1'b0;
        paddr = 32'h0004_0100;
        pwdata = 32'h7777_7777;
        psel_a = 1'b1;
        wait_cyc(1);
        penable = 1'b1;
        wait_cyc(4);
        check("t6_addr_before", 64'(addr_a), 64'h40);
        psel_a = 1'b0;
        penable = 1'b0;
        rstn = 1'b0;
        #2;
        check("t6_prdata", 64'(prdata_a), 64'h0);
        check("t6_pready", 64'(pready_a), 64'h0);
        check("t6_pslverr", 64'(pslverr_a), 64'h0);
        check("t6_valid", 64'(valid_a), 64'h0);
        check("t6_addr", 64'(addr_a), 64'h0);
        check("t6_wdat", 64'(wdat_a), 64'h0);
        wait_cyc(1);
        rstn = 1'b1;
        wait_cyc(1);
        check("t6_no_replay", 64'(valid_a), 64'h0);
        wait_cyc(1);
        fork
            apb_xfer(1'b0, 1'b0, 32'h0004_0008, 32'h0, 3, 1'b0, 1'b1, 32'h6666_0006);
            begin
                wait_cyc(3);
                rvalid = 3'b010;
                rdata[63:32] = 32'h6666_0006;
                wait_cyc(1);
                rvalid = 3'b000;
            end
        join
        ready = '0;
        wait_cyc(3);

        check("a_queue_empty", 64'(exp_a_q.size()), 64'h0);
        check("b_queue_empty", 64'(exp_b_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
